// File: rtl/traffic_pkg.sv
// Light codes and transition rules shared by the traffic queue sensor blocks.
// Latency: none (types, constants and a pure function only).
// Backpressure: none; nothing in this package holds state.
package traffic_pkg;

  // Light code as seen on the via1/via2 wires. Code 3 is never driven by a healthy controller.
  typedef enum logic [1:0] {
    ROSSO   = 2'd0,
    GIALLO  = 2'd1,
    VERDE   = 2'd2,
    ILLEGAL = 2'd3
  } light_t;

  // Legal cycle: R->R, R->V, V->V, V->G, G->G, G->R. Anything else, or anything touching
  // ILLEGAL, is a sequencing fault.
  function automatic logic seq_legal(input light_t prev, input light_t cur);
    logic ok;
    ok = 1'b0;
    case (prev)
      ROSSO:   ok = (cur == ROSSO)  || (cur == VERDE);
      VERDE:   ok = (cur == VERDE)  || (cur == GIALLO);
      GIALLO:  ok = (cur == GIALLO) || (cur == ROSSO);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/road_queue.sv
// One road: vehicle queue counter, green-light departure pacing, overflow and light-sequence check.
// Latency: arrival/departure reflected in q the cycle after the edge; first departure DEP_CYC edges into green.
// Backpressure: none; arrivals at QMAX are dropped and flagged in sticky ovf.
// Ports: clock, reset (sync, active-high); arr (arrival pulse); via (light code);
//        q (queue length); dep (departure pulse); ovf, err_seq (sticky flags).
module road_queue
  import traffic_pkg::*;
#(
  parameter int QW      = 4,
  parameter int QMAX    = 15,
  parameter int DEP_CYC = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arr,
  input  light_t        via,
  output logic [QW-1:0] q,
  output logic          dep,
  output logic          ovf,
  output logic          err_seq
);

  // A one-cycle pacing period still needs a 1-bit timer that simply stays at 0.
  localparam int TW = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;

  logic [QW-1:0] r_q;
  logic [TW-1:0] r_timer;
  logic          r_dep;
  logic          r_ovf;
  logic          r_err_seq;
  light_t        r_prev;

  logic          w_run;
  logic          w_depart;
  logic          w_full;

  // The timer only advances while vehicles are waiting under green.
  assign w_run    = (via == VERDE) && (r_q != '0);
  assign w_depart = w_run && (r_timer == TW'(DEP_CYC - 1));
  assign w_full   = (r_q == QW'(QMAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_q       <= '0;
      r_timer   <= '0;
      r_dep     <= 1'b0;
      r_ovf     <= 1'b0;
      r_err_seq <= 1'b0;
      r_prev    <= ROSSO;
    end else begin
      r_timer <= (!w_run || w_depart) ? '0 : r_timer + 1'b1;
      r_dep   <= w_depart;

      // Arrival and departure together leave q untouched, even when full.
      if (arr && !w_depart) begin
        if (w_full) r_ovf <= 1'b1;
        else        r_q   <= r_q + 1'b1;
      end else if (!arr && w_depart) begin
        r_q <= r_q - 1'b1;
      end

      r_prev <= via;
      if (!seq_legal(r_prev, via)) r_err_seq <= 1'b1;
    end
  end

  assign q       = r_q;
  assign dep     = r_dep;
  assign ovf     = r_ovf;
  assign err_seq = r_err_seq;

endmodule

// File: rtl/traffic_queue_sensor.sv
// Road-side end of the two-road light interface: per-road queues drive demand sensors; light codes are checked.
// Latency: q/sens/dep/flags update one edge after the causing input; sens is a pure decode of registered q.
// Backpressure: none; queue overflow drops the arrival and raises sticky ovf.
// Ports: clock, reset (sync, active-high); arr1/arr2, via1/via2 in; sens1/sens2, q1/q2, dep1/dep2,
//        ovf[1:0], err_conf, err_code, err_seq[1:0] out.
module traffic_queue_sensor
  import traffic_pkg::*;
#(
  parameter int QW      = 4,
  parameter int QMAX    = 15,
  parameter int DEP_CYC = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          arr1,
  input  logic          arr2,
  input  logic [1:0]    via1,
  input  logic [1:0]    via2,
  output logic          sens1,
  output logic          sens2,
  output logic [QW-1:0] q1,
  output logic [QW-1:0] q2,
  output logic          dep1,
  output logic          dep2,
  output logic [1:0]    ovf,
  output logic          err_conf,
  output logic          err_code,
  output logic [1:0]    err_seq
);

  light_t        w_via1;
  light_t        w_via2;
  logic [QW-1:0] w_q1;
  logic [QW-1:0] w_q2;
  logic          w_ovf1;
  logic          w_ovf2;
  logic          w_seq1;
  logic          w_seq2;
  logic          r_err_conf;
  logic          r_err_code;

  assign w_via1 = light_t'(via1);
  assign w_via2 = light_t'(via2);

  road_queue #(.QW(QW), .QMAX(QMAX), .DEP_CYC(DEP_CYC)) u_road1 (
    .clock   (clock),
    .reset   (reset),
    .arr     (arr1),
    .via     (w_via1),
    .q       (w_q1),
    .dep     (dep1),
    .ovf     (w_ovf1),
    .err_seq (w_seq1)
  );

  road_queue #(.QW(QW), .QMAX(QMAX), .DEP_CYC(DEP_CYC)) u_road2 (
    .clock   (clock),
    .reset   (reset),
    .arr     (arr2),
    .via     (w_via2),
    .q       (w_q2),
    .dep     (dep2),
    .ovf     (w_ovf2),
    .err_seq (w_seq2)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_conf <= 1'b0;
      r_err_code <= 1'b0;
    end else begin
      // GIALLO counts as open: any non-ROSSO overlap is a conflict.
      if ((w_via1 != ROSSO) && (w_via2 != ROSSO)) r_err_conf <= 1'b1;
      if ((w_via1 == ILLEGAL) || (w_via2 == ILLEGAL)) r_err_code <= 1'b1;
    end
  end

  assign q1       = w_q1;
  assign q2       = w_q2;
  assign sens1    = (w_q1 != '0);
  assign sens2    = (w_q2 != '0);
  assign ovf      = {w_ovf2, w_ovf1};
  assign err_seq  = {w_seq2, w_seq1};
  assign err_conf = r_err_conf;
  assign err_code = r_err_code;

endmodule
